// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: data width, register file geometry and
// the register-dump FSM state encoding.
package riscv_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned NUM_GPR  = 32;
  localparam int unsigned PC_INDEX = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2,
    ST_DONE  = 2'd3
  } dump_state_e;

endpackage

// File: rtl/regfile_dump_reader.sv
// Streams x0..x31 (and optionally the PC) out of a halted core's register
// file through the RS1 read port, one valid/ready beat per register.
module regfile_dump_reader #(
  parameter bit          INCLUDE_PC = 1'b1,
  parameter int unsigned XLEN       = riscv_pkg::XLEN
) (
  input  logic            CK_REF,
  input  logic            RST_N,
  input  logic            HALTED,
  input  logic            DUMP_REQ,
  input  logic [XLEN-1:0] RS_DATA_IN,
  input  logic [XLEN-1:0] PC_DATA_IN,
  output logic [4:0]      RS_REG_OFFSET,
  output logic            PORT_OWN,
  output logic            DUMP_VALID,
  input  logic            DUMP_READY,
  output logic [XLEN-1:0] DUMP_DATA,
  output logic [5:0]      DUMP_INDEX,
  output logic            DUMP_LAST,
  output logic            DUMP_BUSY,
  output logic            DUMP_DONE,
  output logic            DUMP_ABORT
);

  import riscv_pkg::*;

  localparam int unsigned IDX_W = 6;
  localparam int unsigned OFF_W = 5;
  localparam logic [IDX_W-1:0] PC_IDX   = IDX_W'(PC_INDEX);
  localparam logic [IDX_W-1:0] LAST_IDX = INCLUDE_PC ? PC_IDX : IDX_W'(NUM_GPR - 1);

  dump_state_e       state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              primed_q, primed_d;

  logic [OFF_W-1:0]  offset_d;
  logic              own_d;
  logic              valid_d;
  logic [XLEN-1:0]   data_d;
  logic [IDX_W-1:0]  index_d;
  logic              last_d;
  logic              done_d;
  logic              abort_d;

  logic              start;
  logic              abort_now;

  assign start     = DUMP_REQ && HALTED;
  assign abort_now = !HALTED && ((state_q == ST_FETCH) || (state_q == ST_SEND));
  assign DUMP_BUSY = (state_q != ST_IDLE);

  // State and registered outputs
  always_ff @(posedge CK_REF or negedge RST_N) begin
    if (!RST_N) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      primed_q      <= 1'b0;
      RS_REG_OFFSET <= '0;
      PORT_OWN      <= 1'b0;
      DUMP_VALID    <= 1'b0;
      DUMP_DATA     <= '0;
      DUMP_INDEX    <= '0;
      DUMP_LAST     <= 1'b0;
      DUMP_DONE     <= 1'b0;
      DUMP_ABORT    <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      primed_q      <= primed_d;
      RS_REG_OFFSET <= offset_d;
      PORT_OWN      <= own_d;
      DUMP_VALID    <= valid_d;
      DUMP_DATA     <= data_d;
      DUMP_INDEX    <= index_d;
      DUMP_LAST     <= last_d;
      DUMP_DONE     <= done_d;
      DUMP_ABORT    <= abort_d;
    end
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (!HALTED)       state_d = ST_IDLE;
        else if (primed_q) state_d = ST_SEND;
      end
      ST_SEND: begin
        if (!HALTED)         state_d = ST_IDLE;
        else if (DUMP_READY) state_d = DUMP_LAST ? ST_DONE : ST_FETCH;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath
  always_comb begin
    idx_d    = idx_q;
    primed_d = primed_q;
    offset_d = RS_REG_OFFSET;
    own_d    = PORT_OWN;
    valid_d  = DUMP_VALID;
    data_d   = DUMP_DATA;
    index_d  = DUMP_INDEX;
    last_d   = DUMP_LAST;
    done_d   = 1'b0;
    abort_d  = 1'b0;

    if (abort_now) begin
      // A handshake in this cycle still counts; the sink just sees VALID drop.
      own_d   = 1'b0;
      valid_d = 1'b0;
      last_d  = 1'b0;
      abort_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            idx_d    = '0;
            offset_d = '0;
            own_d    = 1'b1;
            primed_d = 1'b0;
          end
        end
        ST_FETCH: begin
          // The first FETCH after taking the port lets the CPU's RS1 mux settle.
          if (!primed_q) begin
            primed_d = 1'b1;
          end else begin
            data_d  = (idx_q == PC_IDX) ? PC_DATA_IN : RS_DATA_IN;
            index_d = idx_q;
            valid_d = 1'b1;
            last_d  = (idx_q == LAST_IDX);
          end
        end
        ST_SEND: begin
          if (DUMP_READY) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            if (DUMP_LAST) begin
              own_d  = 1'b0;
              done_d = 1'b1;
            end else begin
              idx_d    = idx_q + IDX_W'(1);
              offset_d = OFF_W'(idx_q + IDX_W'(1));
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader: full dump, backpressure, abort,
// no-PC variant, mid-dump reset and ignored requests.
module tb_regfile_dump_reader;

  localparam logic [31:0] PC_VAL = 32'h0000_0040;

  logic        clk = 1'b0;
  logic        rst_n, halted, req, req_np, ready;
  logic        sel_np = 1'b0;
  logic [31:0] rf [32];
  logic [31:0] rs_data, rs_data_np, pc_data;

  logic [4:0]  off, off_np;
  logic        own, valid, last, busy, done, abort;
  logic [31:0] data;
  logic [5:0]  index;
  logic        own_np, valid_np, last_np, busy_np, done_np, abort_np;
  logic [31:0] data_np;
  logic [5:0]  index_np;

  logic        o_own, o_valid, o_last, o_busy, o_done, o_abort;
  logic [31:0] o_data;
  logic [5:0]  o_index;
  logic [48:0] vec, vec_np;

  int errors = 0;
  int checks = 0;

  logic [5:0]  beat_idx[$];
  logic [31:0] beat_data[$];
  logic        beat_last[$];
  int          first_valid, done_cyc, done_cnt, abort_cnt;
  bit          timed_out, stable_bad, own_bad;
  logic        last_valid, last_own, last_abort;

  always #5 clk = ~clk;

  assign rs_data    = rf[off];
  assign rs_data_np = rf[off_np];
  assign pc_data    = PC_VAL;

  assign o_own   = sel_np ? own_np   : own;
  assign o_valid = sel_np ? valid_np : valid;
  assign o_last  = sel_np ? last_np  : last;
  assign o_busy  = sel_np ? busy_np  : busy;
  assign o_done  = sel_np ? done_np  : done;
  assign o_abort = sel_np ? abort_np : abort;
  assign o_data  = sel_np ? data_np  : data;
  assign o_index = sel_np ? index_np : index;

  assign vec    = {own, valid, data, index, last, busy, done, abort, off};
  assign vec_np = {own_np, valid_np, data_np, index_np, last_np, busy_np, done_np, abort_np, off_np};

  regfile_dump_reader #(.INCLUDE_PC(1'b1), .XLEN(32)) dut (
    .CK_REF(clk), .RST_N(rst_n), .HALTED(halted), .DUMP_REQ(req),
    .RS_DATA_IN(rs_data), .PC_DATA_IN(pc_data), .RS_REG_OFFSET(off),
    .PORT_OWN(own), .DUMP_VALID(valid), .DUMP_READY(ready), .DUMP_DATA(data),
    .DUMP_INDEX(index), .DUMP_LAST(last), .DUMP_BUSY(busy), .DUMP_DONE(done),
    .DUMP_ABORT(abort)
  );

  regfile_dump_reader #(.INCLUDE_PC(1'b0), .XLEN(32)) dut_np (
    .CK_REF(clk), .RST_N(rst_n), .HALTED(halted), .DUMP_REQ(req_np),
    .RS_DATA_IN(rs_data_np), .PC_DATA_IN(pc_data), .RS_REG_OFFSET(off_np),
    .PORT_OWN(own_np), .DUMP_VALID(valid_np), .DUMP_READY(ready), .DUMP_DATA(data_np),
    .DUMP_INDEX(index_np), .DUMP_LAST(last_np), .DUMP_BUSY(busy_np), .DUMP_DONE(done_np),
    .DUMP_ABORT(abort_np)
  );

  function automatic logic [31:0] exp_data(input int i);
    if (i == 32) return PC_VAL;
    if (i == 5)  return 32'hDEAD_BEEF;
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  // Starts a dump from #1 after an edge and records beats until BUSY falls.
  task automatic run_dump(input bit np, input int stall_idx, input int stall_len,
                          input int abort_idx, input bit abort_hs, input int extra_req);
    int cyc;
    int stall_cnt;
    bit aborted;
    logic [31:0] snap_d;
    logic [5:0]  snap_i;
    beat_idx.delete(); beat_data.delete(); beat_last.delete();
    first_valid = -1; done_cyc = -1; done_cnt = 0; abort_cnt = 0;
    timed_out = 1'b1; stable_bad = 1'b0; own_bad = 1'b0;
    stall_cnt = 0; aborted = 1'b0; snap_d = '0; snap_i = '0;
    sel_np = np; halted = 1'b1; ready = 1'b1;
    if (np) req_np = 1'b1; else req = 1'b1;
    for (cyc = 0; cyc < 200; cyc++) begin
      @(posedge clk); #1;
      req    = (cyc == extra_req);
      req_np = 1'b0;
      if (o_done)  begin done_cnt++; done_cyc = cyc; end
      if (o_abort) abort_cnt++;
      if (o_valid && first_valid < 0) first_valid = cyc;
      if (o_valid && !o_own) own_bad = 1'b1;
      ready = 1'b1;
      if (o_valid && o_index == 6'(stall_idx)) begin
        if (stall_cnt == 0) begin
          snap_d = o_data; snap_i = o_index;
        end else if (o_data !== snap_d || o_index !== snap_i) begin
          stable_bad = 1'b1;
        end
        if (stall_cnt < stall_len) begin ready = 1'b0; stall_cnt++; end
      end
      if (o_valid && o_index == 6'(abort_idx) && !aborted) begin
        halted = 1'b0; ready = abort_hs; aborted = 1'b1;
      end
      if (o_valid && ready) begin
        beat_idx.push_back(o_index); beat_data.push_back(o_data); beat_last.push_back(o_last);
      end
      last_valid = o_valid; last_own = o_own; last_abort = o_abort;
      if (!o_busy) begin timed_out = 1'b0; break; end
    end
    req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; halted = 1'b0; req = 1'b0; req_np = 1'b0; ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (vec !== 49'd0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", vec); end
    checks++;
    if (vec_np !== 49'd0) begin errors++; $display("FAIL reset_outputs_np: got %h expected 0", vec_np); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy: got %b expected 0", busy); end
  endtask

  task automatic test_full_dump();
    bit bad = 1'b0;
    run_dump(1'b0, -1, 0, -1, 1'b0, -1);
    checks++;
    if (timed_out) begin errors++; $display("FAIL full_timeout: busy did not fall within 200 cycles"); end
    checks++;
    if (first_valid != 2) begin errors++; $display("FAIL full_latency: got %0d expected 2", first_valid); end
    checks++;
    if (beat_idx.size() != 33) begin errors++; $display("FAIL full_beats: got %0d expected 33", beat_idx.size()); end
    foreach (beat_idx[k]) if (beat_idx[k] !== 6'(k) || beat_data[k] !== exp_data(k)) bad = 1'b1;
    checks++;
    if (bad) begin errors++; $display("FAIL full_sequence: index/data order wrong"); end
    checks++;
    if (beat_data.size() < 33 || beat_data[5] !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL full_x5: got %h expected deadbeef", (beat_data.size() > 5) ? beat_data[5] : 32'hx);
    end
    checks++;
    if (beat_data.size() < 33 || beat_data[32] !== PC_VAL || beat_last[32] !== 1'b1 || beat_idx[32] !== 6'd32) begin
      errors++; $display("FAIL full_pc_last: beat 32 not PC 0x40 with LAST");
    end
    checks++;
    if (done_cyc != 67) begin errors++; $display("FAIL full_done_cycle: got %0d expected 67", done_cyc); end
    checks++;
    if (done_cnt != 1 || abort_cnt != 0) begin
      errors++; $display("FAIL full_pulses: done=%0d abort=%0d expected 1 and 0", done_cnt, abort_cnt);
    end
    checks++;
    if (own_bad) begin errors++; $display("FAIL full_port_own: got 0 during a beat expected 1"); end
  endtask

  task automatic test_backpressure();
    bit bad = 1'b0;
    run_dump(1'b0, 3, 4, -1, 1'b0, -1);
    checks++;
    if (timed_out) begin errors++; $display("FAIL bp_timeout: busy did not fall"); end
    checks++;
    if (stable_bad) begin errors++; $display("FAIL bp_stable: data/index changed while stalled"); end
    checks++;
    if (beat_idx.size() != 33) begin errors++; $display("FAIL bp_beats: got %0d expected 33", beat_idx.size()); end
    foreach (beat_idx[k]) if (beat_idx[k] !== 6'(k) || beat_data[k] !== exp_data(k)) bad = 1'b1;
    checks++;
    if (bad) begin errors++; $display("FAIL bp_sequence: beat lost or duplicated"); end
    checks++;
    if (done_cyc != 71 || done_cnt != 1) begin
      errors++; $display("FAIL bp_done: got cycle %0d count %0d expected 71 and 1", done_cyc, done_cnt);
    end
  endtask

  task automatic test_abort();
    run_dump(1'b0, -1, 0, 10, 1'b0, -1);
    checks++;
    if (timed_out) begin errors++; $display("FAIL abort_timeout: busy did not fall"); end
    checks++;
    if (abort_cnt != 1 || last_abort !== 1'b1) begin
      errors++; $display("FAIL abort_pulse: got count %0d expected 1", abort_cnt);
    end
    checks++;
    if (last_valid !== 1'b0 || last_own !== 1'b0) begin
      errors++; $display("FAIL abort_outputs: valid=%b own=%b expected 0 0", last_valid, last_own);
    end
    checks++;
    if (done_cnt != 0) begin errors++; $display("FAIL abort_done: got %0d expected 0", done_cnt); end
    checks++;
    if (beat_idx.size() != 10) begin errors++; $display("FAIL abort_beats: got %0d expected 10", beat_idx.size()); end
    @(posedge clk); #1;
    checks++;
    if (abort !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_width: abort=%b busy=%b expected 0 0", abort, busy);
    end
    halted = 1'b1;
  endtask

  task automatic test_abort_handshake();
    run_dump(1'b0, -1, 0, 4, 1'b1, -1);
    checks++;
    if (beat_idx.size() != 5 || abort_cnt != 1 || done_cnt != 0) begin
      errors++; $display("FAIL abort_hs: beats=%0d abort=%0d done=%0d expected 5 1 0",
                         beat_idx.size(), abort_cnt, done_cnt);
    end
    halted = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_no_pc();
    bit bad = 1'b0;
    int lasts = 0;
    run_dump(1'b1, -1, 0, -1, 1'b0, -1);
    checks++;
    if (beat_idx.size() != 32) begin errors++; $display("FAIL nopc_beats: got %0d expected 32", beat_idx.size()); end
    foreach (beat_idx[k]) begin
      if (beat_idx[k] !== 6'(k) || beat_data[k] !== exp_data(k)) bad = 1'b1;
      if (beat_last[k]) lasts++;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL nopc_sequence: index/data order wrong"); end
    checks++;
    if (lasts != 1 || beat_last.size() != 32 || beat_last[31] !== 1'b1) begin
      errors++; $display("FAIL nopc_last: got %0d LAST beats, expected one on index 31", lasts);
    end
    checks++;
    if (done_cyc != 65 || done_cnt != 1) begin
      errors++; $display("FAIL nopc_done: got cycle %0d count %0d expected 65 and 1", done_cyc, done_cnt);
    end
    sel_np = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    bit pulse = 1'b0;
    sel_np = 1'b0; halted = 1'b1; ready = 1'b1; req = 1'b1;
    for (int c = 0; c < 100 && !found; c++) begin
      @(posedge clk); #1;
      req = 1'b0;
      if (done || abort) pulse = 1'b1;
      if (valid && index == 6'd7) found = 1'b1;
    end
    checks++;
    if (!found || pulse) begin errors++; $display("FAIL rstmid_reach: found=%b pulse=%b expected 1 0", found, pulse); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (vec !== 49'd0) begin errors++; $display("FAIL rstmid_async: got %h expected 0", vec); end
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || abort !== 1'b0) begin
      errors++; $display("FAIL rstmid_after: busy=%b done=%b abort=%b expected 0 0 0", busy, done, abort);
    end
    run_dump(1'b0, -1, 0, -1, 1'b0, -1);
    checks++;
    if (beat_idx.size() != 33 || beat_idx[0] !== 6'd0 || beat_data[0] !== 32'hC0DE_0000 || done_cnt != 1) begin
      errors++; $display("FAIL rstmid_restart: beats=%0d first index=%0d expected 33 from index 0",
                         beat_idx.size(), (beat_idx.size() > 0) ? int'(beat_idx[0]) : -1);
    end
  endtask

  task automatic test_ignored_req();
    bit bad = 1'b0;
    halted = 1'b0; req = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      if (busy || valid || own || abort) bad = 1'b1;
    end
    req = 1'b0; halted = 1'b1;
    checks++;
    if (bad) begin errors++; $display("FAIL ign_unhalted: block left IDLE with HALTED=0"); end
    run_dump(1'b0, -1, 0, -1, 1'b0, 20);
    checks++;
    if (beat_idx.size() != 33 || done_cyc != 67 || done_cnt != 1) begin
      errors++; $display("FAIL ign_busy_req: beats=%0d done cycle=%0d expected 33 and 67", beat_idx.size(), done_cyc);
    end
    bad = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (busy || valid) bad = 1'b1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL ign_queued: a second dump started after DONE"); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = exp_data(i);
    test_reset();
    test_full_dump();
    test_backpressure();
    test_abort();
    test_abort_handshake();
    test_no_pc();
    test_reset_mid();
    test_ignored_req();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
